buffer_controller: RTL and testbench
====================================

BUFFER_CONTROLLER -- requirements
Module: buffer_controller

Interface
REQ-001 SHALL provide parameter NUM_BUFFERS, default 3, number of frame buffers managed (legal range 3..8).
REQ-002 SHALL provide localparam ID_W = $clog2(NUM_BUFFERS), buffer index width.
REQ-003 SHALL provide ports, clock and reset first:
- clk  in  1  single system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- write_request  in  1  camera writer needs a buffer; level, held until write_ack
- write_done  in  1  one-cycle pulse; writer finished its granted buffer
- write_ack  out  1  one-cycle pulse; write_buffer_id/write_valid are valid
- write_buffer_id  out  ID_W  buffer granted to the writer
- write_valid  out  1  1 = grant succeeded; 0 = no AVAILABLE buffer
- read_request  in  1  display reader needs a frame; level, held until read_ack
- read_done  in  1  one-cycle pulse; reader finished its granted buffer
- read_ack  out  1  one-cycle pulse; read_buffer_id/read_valid are valid
- read_buffer_id  out  ID_W  buffer granted to the reader
- read_valid  out  1  1 = frame granted; 0 = no frame yet (show blank)
- buffer_states  out  3*NUM_BUFFERS  per-buffer BufferStates, buffer i at bits [3i+2:3i]
- protocol_error  out  1  sticky flag, set on any protocol violation

Function
REQ-004 SHALL hold one BufferStates register per buffer: AVAILABLE, WRITE_BUSY, READ_BUSY, DISPLAYED, UPDATED.
REQ-005 SHALL run an FSM with states IDLE, WRITE_SEARCH, READ_SEARCH, WRITE_GRANT, READ_GRANT.
REQ-006 IDLE: write_request -> WRITE_SEARCH; else read_request -> READ_SEARCH; both asserted -> WRITE_SEARCH (write priority); the read is served on the next IDLE visit.
REQ-007 WRITE_SEARCH: lowest-index AVAILABLE buffer becomes WRITE_BUSY and its index is latched; none found -> write_valid=0 and protocol_error set; -> WRITE_GRANT.
REQ-008 READ_SEARCH: an UPDATED buffer exists -> it becomes READ_BUSY and any DISPLAYED buffer becomes AVAILABLE; else a DISPLAYED buffer exists -> it becomes READ_BUSY (frame repeat); else read_valid=0 and no state change; -> READ_GRANT.
REQ-009 WRITE_GRANT / READ_GRANT: assert the matching ack for exactly one cycle, then -> IDLE.
REQ-010 Latency: ack asserted exactly 2 cycles after the request is first sampled in IDLE; id/valid held stable from the ack cycle until the next grant to that requester.
REQ-011 write_done: the latched write buffer, if WRITE_BUSY, becomes UPDATED; any other UPDATED buffer becomes AVAILABLE (stale frame dropped), so at most one buffer is UPDATED.
REQ-012 read_done: the latched read buffer, if READ_BUSY, becomes DISPLAYED.
REQ-013 Done pulses SHALL be applied in the cycle asserted, in any FSM state; in a SEARCH cycle the search SHALL use the state vector after that cycle's done updates (done first, then allocation).
REQ-014 A done pulse whose buffer is not in the expected busy state SHALL change no state and SHALL set protocol_error.
REQ-015 A requester's request SHALL be ignored (no re-grant) while its ack is asserted; a request level still high in the cycle after ack starts a new allocation.
REQ-016 Invariants with NUM_BUFFERS>=3 under legal protocol: at most one WRITE_BUSY, at most one of READ_BUSY/DISPLAYED, at most one UPDATED; write_valid is always 1.

Reset
REQ-017 On reset: all buffers AVAILABLE; FSM IDLE; write_ack, read_ack, write_valid, read_valid, protocol_error = 0; write_buffer_id, read_buffer_id = 0.
REQ-018 Reset asserted mid-operation SHALL abandon in-flight grants; no ack SHALL be issued in or after the reset cycle for a request sampled before reset.

Structure
REQ-019 BufferStates SHALL remain in package BufferControllerTypes; the FSM state enum (ControllerStates) SHALL be added to the same package.
REQ-020 SHALL instantiate one sub-module, buffer_state_finder: combinational lowest-index search returning found flag and index for a given BufferStates value; it is used for AVAILABLE, UPDATED and DISPLAYED.

Verification
REQ-021 After reset, read_request -> read_ack at cycle +2, read_valid=0, buffer_states all AVAILABLE.
REQ-022 write_request -> ack id=0 valid=1; write_done -> buf0 UPDATED; read_request -> id=0 valid=1, buf0 READ_BUSY; read_done -> buf0 DISPLAYED.
REQ-023 Writer completes frames into buf1 then buf2 with no read in between -> buf1 returns to AVAILABLE on the second write_done, buf2 UPDATED; next read gets id=2 and buf0 DISPLAYED -> AVAILABLE.
REQ-024 write_request and read_request rise in the same cycle -> write_ack at +2, read_ack at +5; no overlapping acks.
REQ-025 read_done with no READ_BUSY buffer -> states unchanged, protocol_error=1 and held until reset.
REQ-026 Reset pulsed in the WRITE_SEARCH cycle -> no write_ack issued, all buffers AVAILABLE, protocol_error=0.

Source files
------------

// File: rtl/buffer_controller_pkg.sv
// Shared types for the frame-buffer controller: per-buffer lifecycle states,
// controller FSM states and a helper to locate a buffer's slot in the packed state vector.
// Pure declarations; no logic, no latency, no flow control.
package BufferControllerTypes;

    // Encoding is fixed: AVAILABLE must be zero so a cleared state vector means "all free".
    typedef enum logic [2:0] {
        AVAILABLE  = 3'd0,
        WRITE_BUSY = 3'd1,
        READ_BUSY  = 3'd2,
        DISPLAYED  = 3'd3,
        UPDATED    = 3'd4
    } BufferStates;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WRITE_SEARCH = 3'd1,
        READ_SEARCH  = 3'd2,
        WRITE_GRANT  = 3'd3,
        READ_GRANT   = 3'd4
    } ControllerStates;

    localparam int STATE_W = 3;

    // LSB position of buffer idx inside the packed per-buffer state vector.
    function automatic int slot_lsb(input int idx);
        return STATE_W * idx;
    endfunction

endpackage

// File: rtl/buffer_controller_if.sv
// Handshake bundle between camera writer / display reader and the buffer controller.
// Latency: none (wires only). Backpressure: requests are levels held until the matching ack.
// Ports: write/read request+done in, ack+id+valid out, per-buffer state vector, sticky error.
interface buffer_controller_if #(
    parameter int NUM_BUFFERS = 3
);
    localparam int ID_W = $clog2(NUM_BUFFERS);

    logic                     write_request;
    logic                     write_done;
    logic                     write_ack;
    logic [ID_W-1:0]          write_buffer_id;
    logic                     write_valid;
    logic                     read_request;
    logic                     read_done;
    logic                     read_ack;
    logic [ID_W-1:0]          read_buffer_id;
    logic                     read_valid;
    logic [3*NUM_BUFFERS-1:0] buffer_states;
    logic                     protocol_error;

    // Requester side (writer + reader clients).
    modport master (
        output write_request, write_done, read_request, read_done,
        input  write_ack, write_buffer_id, write_valid,
        input  read_ack, read_buffer_id, read_valid,
        input  buffer_states, protocol_error
    );

    // Controller side.
    modport slave (
        input  write_request, write_done, read_request, read_done,
        output write_ack, write_buffer_id, write_valid,
        output read_ack, read_buffer_id, read_valid,
        output buffer_states, protocol_error
    );
endinterface

// File: rtl/buffer_controller_finder.sv
// Lowest-index search for a buffer holding a given lifecycle state.
// Latency: purely combinational. Backpressure: none.
// Ports: states_i packed state vector, target_i state to look for, found_o / index_o result.
module buffer_state_finder
    import BufferControllerTypes::*;
#(
    parameter int NUM_BUFFERS = 3
) (
    input  logic [3*NUM_BUFFERS-1:0]      states_i,
    input  BufferStates                   target_i,
    output logic                          found_o,
    output logic [$clog2(NUM_BUFFERS)-1:0] index_o
);
    localparam int ID_W = $clog2(NUM_BUFFERS);

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        found_o = 1'b0;
        index_o = '0;
        for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
            if (states_i[slot_lsb(i) +: STATE_W] == target_i) begin
                found_o = 1'b1;
                index_o = ID_W'(i);
            end
        end
    end
endmodule

// File: rtl/buffer_controller.sv
// Frame-buffer arbiter: hands buffers to a camera writer and a display reader, tracks lifecycle.
// Latency: ack exactly 2 cycles after a request is sampled in IDLE; done pulses act same cycle.
// Backpressure: requests are levels held until ack; write wins ties, read served next IDLE visit.
// Ports: clk, reset (sync, active-high), bus = controller side of buffer_controller_if.
module buffer_controller
    import BufferControllerTypes::*;
#(
    parameter int NUM_BUFFERS = 3
) (
    input  logic                clk,
    input  logic                reset,
    buffer_controller_if.slave  bus
);
    localparam int ID_W = $clog2(NUM_BUFFERS);
    localparam int SV_W = STATE_W * NUM_BUFFERS;

    ControllerStates  state_q, state_d;
    logic [SV_W-1:0]  buf_q, buf_d;
    logic [SV_W-1:0]  buf_done;          // state vector after this cycle's done pulses
    logic [ID_W-1:0]  wr_id_q, wr_id_d;
    logic [ID_W-1:0]  rd_id_q, rd_id_d;
    logic             wr_vld_q, wr_vld_d;
    logic             rd_vld_q, rd_vld_d;
    logic             err_q, err_d;
    logic             wr_done_err, rd_done_err;

    logic             avail_found, upd_found, disp_found;
    logic [ID_W-1:0]  avail_idx, upd_idx, disp_idx;

    // Done pulses are resolved first so a search in the same cycle sees their effect.
    always_comb begin
        buf_done    = buf_q;
        wr_done_err = 1'b0;
        rd_done_err = 1'b0;
        if (bus.write_done) begin
            if (buf_q[slot_lsb(int'(wr_id_q)) +: STATE_W] == WRITE_BUSY) begin
                // Only the newest finished frame is kept; an older unread one is dropped.
                for (int i = 0; i < NUM_BUFFERS; i++) begin
                    if (buf_q[slot_lsb(i) +: STATE_W] == UPDATED) begin
                        buf_done[slot_lsb(i) +: STATE_W] = AVAILABLE;
                    end
                end
                buf_done[slot_lsb(int'(wr_id_q)) +: STATE_W] = UPDATED;
            end else begin
                wr_done_err = 1'b1;
            end
        end
        if (bus.read_done) begin
            if (buf_done[slot_lsb(int'(rd_id_q)) +: STATE_W] == READ_BUSY) begin
                buf_done[slot_lsb(int'(rd_id_q)) +: STATE_W] = DISPLAYED;
            end else begin
                rd_done_err = 1'b1;
            end
        end
    end

    buffer_state_finder #(.NUM_BUFFERS(NUM_BUFFERS)) u_find_avail (
        .states_i (buf_done),
        .target_i (AVAILABLE),
        .found_o  (avail_found),
        .index_o  (avail_idx)
    );

    buffer_state_finder #(.NUM_BUFFERS(NUM_BUFFERS)) u_find_upd (
        .states_i (buf_done),
        .target_i (UPDATED),
        .found_o  (upd_found),
        .index_o  (upd_idx)
    );

    buffer_state_finder #(.NUM_BUFFERS(NUM_BUFFERS)) u_find_disp (
        .states_i (buf_done),
        .target_i (DISPLAYED),
        .found_o  (disp_found),
        .index_o  (disp_idx)
    );

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_done;
        wr_id_d  = wr_id_q;
        rd_id_d  = rd_id_q;
        wr_vld_d = wr_vld_q;
        rd_vld_d = rd_vld_q;
        err_d    = err_q | wr_done_err | rd_done_err;

        case (state_q)
            IDLE: begin
                if (bus.write_request) begin
                    state_d = WRITE_SEARCH;
                end else if (bus.read_request) begin
                    state_d = READ_SEARCH;
                end
            end

            WRITE_SEARCH: begin
                if (avail_found) begin
                    buf_d[slot_lsb(int'(avail_idx)) +: STATE_W] = WRITE_BUSY;
                    wr_id_d  = avail_idx;
                    wr_vld_d = 1'b1;
                end else begin
                    // Writer asked for more buffers than exist; keep the old id, flag it.
                    wr_vld_d = 1'b0;
                    err_d    = 1'b1;
                end
                state_d = WRITE_GRANT;
            end

            READ_SEARCH: begin
                if (upd_found) begin
                    // Fresh frame: the previously shown one is no longer needed.
                    for (int i = 0; i < NUM_BUFFERS; i++) begin
                        if (buf_done[slot_lsb(i) +: STATE_W] == DISPLAYED) begin
                            buf_d[slot_lsb(i) +: STATE_W] = AVAILABLE;
                        end
                    end
                    buf_d[slot_lsb(int'(upd_idx)) +: STATE_W] = READ_BUSY;
                    rd_id_d  = upd_idx;
                    rd_vld_d = 1'b1;
                end else if (disp_found) begin
                    // No new frame: show the last one again.
                    buf_d[slot_lsb(int'(disp_idx)) +: STATE_W] = READ_BUSY;
                    rd_id_d  = disp_idx;
                    rd_vld_d = 1'b1;
                end else begin
                    rd_vld_d = 1'b0;
                end
                state_d = READ_GRANT;
            end

            // Request lines are not looked at here, so a held request cannot be re-granted
            // in the ack cycle; it is picked up again once back in IDLE.
            WRITE_GRANT: state_d = IDLE;
            READ_GRANT:  state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            buf_q    <= '0;  // AVAILABLE encodes as zero
            wr_id_q  <= '0;
            rd_id_q  <= '0;
            wr_vld_q <= 1'b0;
            rd_vld_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            wr_id_q  <= wr_id_d;
            rd_id_q  <= rd_id_d;
            wr_vld_q <= wr_vld_d;
            rd_vld_q <= rd_vld_d;
            err_q    <= err_d;
        end
    end

    // Acks are masked by reset so a grant in flight never surfaces in the reset cycle.
    assign bus.write_ack       = (state_q == WRITE_GRANT) && !reset;
    assign bus.read_ack        = (state_q == READ_GRANT) && !reset;
    assign bus.write_buffer_id = wr_id_q;
    assign bus.write_valid     = wr_vld_q;
    assign bus.read_buffer_id  = rd_id_q;
    assign bus.read_valid      = rd_vld_q;
    assign bus.buffer_states   = buf_q;
    assign bus.protocol_error  = err_q;

endmodule

// File: tb/tb_buffer_controller.sv
// Directed bench for buffer_controller with three buffers and hand-computed expectations.
module tb_buffer_controller;
    import BufferControllerTypes::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    buffer_controller_if #(.NUM_BUFFERS(3)) bus ();

    buffer_controller #(.NUM_BUFFERS(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] st3(BufferStates b0, BufferStates b1, BufferStates b2);
        return {b2, b1, b0};
    endfunction

    task automatic pulse_done(input logic w, input logic r);
        bus.write_done = w;
        bus.read_done  = r;
        tick();
        bus.write_done = 1'b0;
        bus.read_done  = 1'b0;
    endtask

    task automatic do_write(input string tag, input int exp_id, input logic exp_vld);
        bus.write_request = 1'b1;
        tick();
        chk({tag, "_ack_early"}, 32'(bus.write_ack), 0);
        tick();
        chk({tag, "_ack"}, 32'(bus.write_ack), 1);
        chk({tag, "_id"}, 32'(bus.write_buffer_id), exp_id);
        chk({tag, "_valid"}, 32'(bus.write_valid), 32'(exp_vld));
        bus.write_request = 1'b0;
        tick();
        chk({tag, "_ack_drop"}, 32'(bus.write_ack), 0);
    endtask

    task automatic do_read(input string tag, input int exp_id, input logic exp_vld);
        bus.read_request = 1'b1;
        tick();
        chk({tag, "_ack_early"}, 32'(bus.read_ack), 0);
        tick();
        chk({tag, "_ack"}, 32'(bus.read_ack), 1);
        chk({tag, "_id"}, 32'(bus.read_buffer_id), exp_id);
        chk({tag, "_valid"}, 32'(bus.read_valid), 32'(exp_vld));
        bus.read_request = 1'b0;
        tick();
        chk({tag, "_ack_drop"}, 32'(bus.read_ack), 0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        bus.write_request = 1'b0;
        bus.write_done    = 1'b0;
        bus.read_request  = 1'b0;
        bus.read_done     = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_states", 32'(bus.buffer_states), 0);
        chk("rst_wack", 32'(bus.write_ack), 0);
        chk("rst_rack", 32'(bus.read_ack), 0);
        chk("rst_wvalid", 32'(bus.write_valid), 0);
        chk("rst_rvalid", 32'(bus.read_valid), 0);
        chk("rst_err", 32'(bus.protocol_error), 0);
        chk("rst_wid", 32'(bus.write_buffer_id), 0);
        chk("rst_rid", 32'(bus.read_buffer_id), 0);
        reset = 1'b0;
        tick();

        // Read with nothing written: blank frame
        do_read("rd_empty", 0, 1'b0);
        chk("rd_empty_states", 32'(bus.buffer_states), 32'(st3(AVAILABLE, AVAILABLE, AVAILABLE)));

        // Basic write -> read -> display cycle on buf0
        do_write("wr0", 0, 1'b1);
        chk("wr0_states", 32'(bus.buffer_states), 32'(st3(WRITE_BUSY, AVAILABLE, AVAILABLE)));
        pulse_done(1'b1, 1'b0);
        chk("wr0_done", 32'(bus.buffer_states), 32'(st3(UPDATED, AVAILABLE, AVAILABLE)));
        do_read("rd0", 0, 1'b1);
        chk("rd0_states", 32'(bus.buffer_states), 32'(st3(READ_BUSY, AVAILABLE, AVAILABLE)));
        pulse_done(1'b0, 1'b1);
        chk("rd0_done", 32'(bus.buffer_states), 32'(st3(DISPLAYED, AVAILABLE, AVAILABLE)));

        // Two frames written with no read: the older one is dropped
        do_write("wr1", 1, 1'b1);
        pulse_done(1'b1, 1'b0);
        chk("wr1_done", 32'(bus.buffer_states), 32'(st3(DISPLAYED, UPDATED, AVAILABLE)));
        do_write("wr2", 2, 1'b1);
        pulse_done(1'b1, 1'b0);
        chk("wr2_done", 32'(bus.buffer_states), 32'(st3(DISPLAYED, AVAILABLE, UPDATED)));
        do_read("rd2", 2, 1'b1);
        chk("rd2_states", 32'(bus.buffer_states), 32'(st3(AVAILABLE, AVAILABLE, READ_BUSY)));
        pulse_done(1'b0, 1'b1);
        chk("rd2_done", 32'(bus.buffer_states), 32'(st3(AVAILABLE, AVAILABLE, DISPLAYED)));

        // Simultaneous requests: write at +2, read at +5, no overlap
        bus.write_request = 1'b1;
        bus.read_request  = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            chk($sformatf("both_wack_c%0d", c), 32'(bus.write_ack), (c == 2) ? 1 : 0);
            chk($sformatf("both_rack_c%0d", c), 32'(bus.read_ack), (c == 5) ? 1 : 0);
            if (c == 2) begin
                chk("both_wid", 32'(bus.write_buffer_id), 0);
                chk("both_wvalid", 32'(bus.write_valid), 1);
                bus.write_request = 1'b0;
            end
            if (c == 5) begin
                chk("both_rid", 32'(bus.read_buffer_id), 2);
                chk("both_rvalid", 32'(bus.read_valid), 1);
                bus.read_request = 1'b0;
            end
        end
        chk("both_states", 32'(bus.buffer_states), 32'(st3(WRITE_BUSY, AVAILABLE, READ_BUSY)));

        // Both done pulses in one cycle
        pulse_done(1'b1, 1'b1);
        chk("dual_done", 32'(bus.buffer_states), 32'(st3(UPDATED, AVAILABLE, DISPLAYED)));
        chk("dual_err", 32'(bus.protocol_error), 0);

        do_read("rd_new", 0, 1'b1);
        chk("rd_new_states", 32'(bus.buffer_states), 32'(st3(READ_BUSY, AVAILABLE, AVAILABLE)));

        // read_done in the search cycle is applied before the search (frame repeat of buf0)
        bus.read_request = 1'b1;
        tick();
        bus.read_done = 1'b1;
        chk("dis_ack_early", 32'(bus.read_ack), 0);
        tick();
        bus.read_done = 1'b0;
        chk("dis_ack", 32'(bus.read_ack), 1);
        chk("dis_valid", 32'(bus.read_valid), 1);
        chk("dis_id", 32'(bus.read_buffer_id), 0);
        chk("dis_states", 32'(bus.buffer_states), 32'(st3(READ_BUSY, AVAILABLE, AVAILABLE)));
        bus.read_request = 1'b0;
        tick();
        pulse_done(1'b0, 1'b1);
        chk("dis_done", 32'(bus.buffer_states), 32'(st3(DISPLAYED, AVAILABLE, AVAILABLE)));
        chk("dis_err", 32'(bus.protocol_error), 0);

        // Illegal read_done: no state change, sticky error
        pulse_done(1'b0, 1'b1);
        chk("bad_rd_states", 32'(bus.buffer_states), 32'(st3(DISPLAYED, AVAILABLE, AVAILABLE)));
        chk("bad_rd_err", 32'(bus.protocol_error), 1);
        tick();
        tick();
        tick();
        chk("bad_rd_err_held", 32'(bus.protocol_error), 1);

        // Reset during WRITE_SEARCH abandons the grant
        bus.write_request = 1'b1;
        tick();
        reset = 1'b1;
        bus.write_request = 1'b0;
        tick();
        chk("rst_ws_wack", 32'(bus.write_ack), 0);
        chk("rst_ws_states", 32'(bus.buffer_states), 0);
        chk("rst_ws_err", 32'(bus.protocol_error), 0);
        chk("rst_ws_wvalid", 32'(bus.write_valid), 0);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("rst_ws_wack_after%0d", c), 32'(bus.write_ack), 0);
        end

        // Writer grabbing buffers without releasing them exhausts the pool
        do_write("ex0", 0, 1'b1);
        do_write("ex1", 1, 1'b1);
        do_write("ex2", 2, 1'b1);
        chk("ex_err_before", 32'(bus.protocol_error), 0);
        do_write("ex3", 2, 1'b0);
        chk("ex_err", 32'(bus.protocol_error), 1);
        chk("ex_states", 32'(bus.buffer_states), 32'(st3(WRITE_BUSY, WRITE_BUSY, WRITE_BUSY)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
